// File: rtl/raster_irq_if.sv
// Register bus between the CPU side and raster_irq.
// Write strobe/address/data, read address, registered read data and irq.
interface raster_irq_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic        irq;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, irq
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, irq
    );
endinterface

// File: rtl/raster_irq.sv
// Raster interrupt: vblank/line events, W1C status, frame counter.
// Line compare feature is built only when RASTER_IRQ_LINE_EN is defined.
module raster_irq #(
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        visible,
    input  logic [15:0] y,
    raster_irq_if.slave bus
);

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_STAT = 2'd1;
    localparam logic [1:0] A_LCMP = 2'd2;
    localparam logic [1:0] A_FRM  = 2'd3;

`ifdef RASTER_IRQ_LINE_EN
    localparam logic [1:0] MASK = 2'b11;
`else
    localparam logic [1:0] MASK = 2'b01;
`endif

    logic [1:0]  ctrl_q, ctrl_nx;
    logic [1:0]  pend_q, pend_nx;
    logic [1:0]  ev;
    logic [15:0] frame_q;
    logic [15:0] lcmp_rd;
    logic [15:0] rd_nx;
    logic        vs_n, vs_q;
    logic        vblank_ev, line_ev;
    logic        wr_ctrl, wr_stat;

    assign vs_n      = VSYNC_ACTIVE_HIGH ? vsync : ~vsync;
    assign vblank_ev = vs_n & ~vs_q;
    assign wr_ctrl   = bus.wr_en && (bus.wr_addr == A_CTRL);
    assign wr_stat   = bus.wr_en && (bus.wr_addr == A_STAT);

`ifdef RASTER_IRQ_LINE_EN
    logic [15:0] lcmp_q;
    logic        vis_q;

    assign line_ev = visible & ~vis_q & (y == lcmp_q);
    assign lcmp_rd = lcmp_q;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            lcmp_q <= '0;
            vis_q  <= 1'b1;
        end else begin
            vis_q <= visible;
            if (bus.wr_en && (bus.wr_addr == A_LCMP))
                lcmp_q <= bus.wr_data;
        end
    end
`else
    logic unused_line;

    assign unused_line = ^{visible, y, bus.wr_data[15:2]};
    assign line_ev     = 1'b0;
    assign lcmp_rd     = '0;
`endif

    // Set wins over W1C: clear first, then OR in gated events.
    always_comb begin
        ctrl_nx = ctrl_q;
        if (wr_ctrl)
            ctrl_nx = bus.wr_data[1:0] & MASK;
        ev      = {line_ev & ctrl_q[1], vblank_ev & ctrl_q[0]};
        pend_nx = pend_q;
        if (wr_stat)
            pend_nx = pend_q & ~bus.wr_data[1:0];
        pend_nx = (pend_nx | ev) & MASK;
    end

    always_comb begin
        rd_nx = '0;
        unique case (bus.rd_addr)
            A_CTRL: rd_nx = {14'd0, ctrl_q};
            A_STAT: rd_nx = {14'd0, pend_q};
            A_LCMP: rd_nx = lcmp_rd;
            A_FRM:  rd_nx = frame_q;
            default: rd_nx = '0;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= '0;
            pend_q      <= '0;
            frame_q     <= '0;
            vs_q        <= 1'b1;
            bus.rd_data <= '0;
            bus.irq     <= 1'b0;
        end else begin
            vs_q        <= vs_n;
            ctrl_q      <= ctrl_nx;
            pend_q      <= pend_nx;
            bus.rd_data <= rd_nx;
            bus.irq     <= |(pend_nx & ctrl_nx);
            if (vblank_ev)
                frame_q <= frame_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_raster_irq.sv
// Directed bench for raster_irq with a cycle-level reference model.
// Builds with or without RASTER_IRQ_LINE_EN.
module tb_raster_irq;

`ifdef RASTER_IRQ_LINE_EN
    localparam bit LINE = 1'b1;
`else
    localparam bit LINE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vsync = 1'b0;
    logic        visible = 1'b0;
    logic [15:0] y = '0;

    int errors = 0;
    int checks = 0;

    raster_irq_if bus ();

    raster_irq #(.VSYNC_ACTIVE_HIGH(1'b1)) dut (
        .pixel_clk(clk),
        .reset_n  (reset_n),
        .vsync    (vsync),
        .visible  (visible),
        .y        (y),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model: register file state as the CPU sees it.
    logic [1:0]  m_ctrl, m_pend;
    logic [15:0] m_cmp, m_frame, m_rd;
    logic        m_irq, p_vs, p_vis, m_ok = 1'b0;

    always @(posedge clk) begin : mdl
        logic       vb, ln;
        logic [1:0] np, nc;
        if (!reset_n) begin
            m_ctrl  <= '0;
            m_pend  <= '0;
            m_cmp   <= '0;
            m_frame <= '0;
            m_rd    <= '0;
            m_irq   <= 1'b0;
            p_vs    <= 1'b1;
            p_vis   <= 1'b1;
            m_ok    <= 1'b1;
        end else begin
            vb = vsync && !p_vs;
            ln = LINE && visible && !p_vis && (y == m_cmp);
            case (bus.rd_addr)
                2'd0:    m_rd <= {14'd0, m_ctrl};
                2'd1:    m_rd <= {14'd0, m_pend};
                2'd2:    m_rd <= LINE ? m_cmp : 16'd0;
                default: m_rd <= m_frame;
            endcase
            np = m_pend;
            if (bus.wr_en && bus.wr_addr == 2'd1)
                np = np & ~bus.wr_data[1:0];
            if (vb && m_ctrl[0]) np[0] = 1'b1;
            if (ln && m_ctrl[1]) np[1] = 1'b1;
            nc = m_ctrl;
            if (bus.wr_en && bus.wr_addr == 2'd0)
                nc = bus.wr_data[1:0] & (LINE ? 2'b11 : 2'b01);
            if (LINE && bus.wr_en && bus.wr_addr == 2'd2)
                m_cmp <= bus.wr_data;
            m_frame <= m_frame + (vb ? 16'd1 : 16'd0);
            m_pend  <= np;
            m_ctrl  <= nc;
            m_irq   <= |(np & nc);
            p_vs    <= vsync;
            p_vis   <= visible;
        end
    end

    always @(negedge clk) begin
        if (reset_n && m_ok) begin
            checks++;
            if (bus.rd_data !== m_rd || bus.irq !== m_irq) begin
                errors++;
                $display("FAIL cycle_model t=%0t rd_data=%h irq=%b expected rd_data=%h irq=%b",
                         $time, bus.rd_data, bus.irq, m_rd, m_irq);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [15:0] exp,
                          input string name);
        bus.rd_addr = a;
        @(negedge clk);
        chk(name, bus.rd_data, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_data", bus.rd_data, 16'h0);
        chk("rst_irq", {15'd0, bus.irq}, 16'h0);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;

        do_reset();
        rd_chk(2'd3, 16'h0000, "frame_rst");
        rd_chk(2'd0, 16'h0000, "ctrl_rst");

        // vblank with enable
        wr(2'd0, 16'h0001);
        vsync = 1'b1;
        @(negedge clk);
        chk("irq_vblank", {15'd0, bus.irq}, 16'h1);
        rd_chk(2'd1, 16'h0001, "pend_vblank");
        rd_chk(2'd3, 16'h0001, "frame_one");
        vsync = 1'b0;
        wr(2'd1, 16'h0001);
        chk("irq_w1c", {15'd0, bus.irq}, 16'h0);
        rd_chk(2'd1, 16'h0000, "pend_w1c");

        // event and clear in the same cycle
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        wr(2'd1, 16'h0001);
        chk("irq_set_clr", {15'd0, bus.irq}, 16'h1);
        vsync = 1'b0;
        rd_chk(2'd1, 16'h0001, "pend_set_clr");

        // enable masks irq, pending kept
        wr(2'd0, 16'h0000);
        chk("irq_masked", {15'd0, bus.irq}, 16'h0);
        rd_chk(2'd1, 16'h0001, "pend_masked");
        wr(2'd1, 16'h0001);
        rd_chk(2'd1, 16'h0000, "pend_cleared");

        // line compare
        wr(2'd2, 16'h0010);
        wr(2'd0, 16'h0002);
        y = 16'h0010;
        visible = 1'b1;
        @(negedge clk);
        chk("irq_line", {15'd0, bus.irq}, {15'd0, LINE});
        rd_chk(2'd1, LINE ? 16'h0002 : 16'h0000, "pend_line");
        rd_chk(2'd2, LINE ? 16'h0010 : 16'h0000, "lcmp_rd");
        wr(2'd1, 16'h0002);
        visible = 1'b0;
        y = 16'h0011;
        @(negedge clk);
        visible = 1'b1;
        @(negedge clk);
        chk("irq_line_miss", {15'd0, bus.irq}, 16'h0);
        rd_chk(2'd1, 16'h0000, "pend_line_miss");
        visible = 1'b0;

        // register masks and read-only frame
        wr(2'd2, 16'h1234);
        wr(2'd0, 16'h0003);
        rd_chk(2'd2, LINE ? 16'h1234 : 16'h0000, "lcmp_1234");
        rd_chk(2'd0, LINE ? 16'h0003 : 16'h0001, "ctrl_mask");
        wr(2'd3, 16'hBEEF);
        rd_chk(2'd3, 16'h0003, "frame_ro");

        // read and write same register same cycle
        bus.rd_addr = 2'd0;
        wr(2'd0, 16'h0000);
        chk("rd_pre_write", bus.rd_data, LINE ? 16'h0003 : 16'h0001);
        @(negedge clk);
        chk("rd_post_write", bus.rd_data, 16'h0000);

        // vsync held active through reset release
        vsync = 1'b1;
        do_reset();
        rd_chk(2'd3, 16'h0000, "frame_hold");
        rd_chk(2'd1, 16'h0000, "pend_hold");
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        rd_chk(2'd3, 16'h0001, "frame_after_hold");

        // frame counter wrap with all enables off
        vsync = 1'b0;
        do_reset();
        bus.rd_addr = 2'd3;
        for (int i = 0; i < 65535; i++) begin
            vsync = 1'b1;
            @(negedge clk);
            vsync = 1'b0;
            @(negedge clk);
        end
        rd_chk(2'd3, 16'hFFFF, "frame_ffff");
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        rd_chk(2'd3, 16'h0000, "frame_wrap");
        chk("irq_wrap", {15'd0, bus.irq}, 16'h0);
        rd_chk(2'd1, 16'h0000, "pend_wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/raster_irq.md
RASTER_IRQ -- requirements
Module: raster_irq

Interface
REQ-001 SHALL have parameter: VSYNC_ACTIVE_HIGH, 1, vsync polarity (1 = high marks the sync pulse, 0 = low marks it).
REQ-002 SHALL have port: pixel_clk  in  1  sole clock, same clock as display timing.
REQ-003 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: vsync  in  1  vertical sync from the timing generator.
REQ-005 SHALL have port: visible  in  1  active-video flag from the timing generator.
REQ-006 SHALL have port: y  in  16  current line number from the timing generator.
REQ-007 SHALL have port: wr_en  in  1  register write strobe, one write per asserted cycle.
REQ-008 SHALL have port: wr_addr  in  2  write register index.
REQ-009 SHALL have port: wr_data  in  16  write data.
REQ-010 SHALL have port: rd_addr  in  2  read register index, sampled every cycle.
REQ-011 SHALL have port: rd_data  out  16  registered read data.
REQ-012 SHALL have port: irq  out  1  level interrupt to the CPU.

Function
REQ-013 SHALL implement registers: 0 CTRL {bit0 vblank_en, bit1 line_en}; 1 STATUS {bit0 vblank_pend, bit1 line_pend}; 2 LINE_CMP (16b R/W); 3 FRAME (16b read-only).
REQ-014 SHALL keep one registered copy each of vsync (normalized to active-high per VSYNC_ACTIVE_HIGH) and visible for edge detection.
REQ-015 SHALL detect vblank event: normalized vsync = 1 at a clock edge where its registered copy = 0.
REQ-016 SHALL detect line event: visible = 1 and visible copy = 0 and y == LINE_CMP, all at the same clock edge.
REQ-017 SHALL increment FRAME by 1 on every vblank event, regardless of enables, wrapping 0xFFFF -> 0x0000.
REQ-018 SHALL set vblank_pend at the event edge only if vblank_en = 1; SHALL set line_pend at the event edge only if line_en = 1.
REQ-019 SHALL clear STATUS bits written as 1 (W1C); bits written as 0 unchanged; a set and a clear in the same cycle SHALL leave the bit set.
REQ-020 SHALL ignore writes to FRAME; CTRL bits 15:2 ignored, read 0.
REQ-021 SHALL register irq = OR over (pend & en) computed from next-state values, so irq rises on the same edge that sets pending and falls on the edge that clears pending or enable.
REQ-022 SHALL clearing an enable mask irq but retain the pending bit.
REQ-023 SHALL present rd_data one cycle after rd_addr; reads SHALL have no side effects.
REQ-024 SHALL, when a read and a write target the same register in one cycle, return the pre-write value.

Reset
REQ-025 SHALL asynchronously on reset_n = 0: CTRL, STATUS, LINE_CMP, FRAME, rd_data, irq = 0.
REQ-026 SHALL initialize edge-detect copies to 1 so an input already active at reset release raises no event.
REQ-027 SHALL, on reset mid-frame, discard partial events; first vblank event after release SHALL set FRAME = 1.

Configuration
REQ-028 SHALL with RASTER_IRQ_LINE_EN defined implement line event, line_en, line_pend, LINE_CMP as above.
REQ-029 SHALL without RASTER_IRQ_LINE_EN: no line-event logic; CTRL bit1, STATUS bit1, LINE_CMP read 0, writes ignored; irq from vblank only.

Verification
REQ-030 SHALL test: reset, CTRL=0x1, vsync 0->1 -> vblank_pend=1, irq=1 same edge, FRAME=1; W1C STATUS=0x1 -> irq=0 next edge.
REQ-031 SHALL test: FRAME preloaded via 65536 vblank events with CTRL=0 -> FRAME wraps to 0x0000, irq stays 0, STATUS=0.
REQ-032 SHALL test: LINE_CMP=0x0010, CTRL=0x2, visible rising at y=0x0010 -> line_pend=1, irq=1; rising at y=0x0011 -> no event.
REQ-033 SHALL test: vblank event and W1C STATUS=0x1 same cycle -> vblank_pend remains 1, irq stays 1.
REQ-034 SHALL test: vsync held 1 through reset release -> no event, FRAME=0; next 0->1 -> FRAME=1.
REQ-035 SHALL test: build without RASTER_IRQ_LINE_EN, write LINE_CMP=0x1234, CTRL=0x3 -> reads LINE_CMP=0x0000, CTRL=0x0001.
